fetch_queue: RTL and testbench

- Consumer and controller side of the instruction fetch interface.
- Drives the byte address `fetch_pc` into the fetch stage and captures the instruction pair that fetch returns one clock later (`fetch_inst1` from bytes pc..pc+3, `fetch_inst2` from bytes pc+4..pc+7).
- Buffers the pair in a circular queue and presents up to two instructions per cycle to decode.
- Handles back-pressure through a credit check, and handles branch redirects by flushing.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch controller and two-wide decode queue.
// Optional stall performance counter enabled by FETCH_QUEUE_PERF_CNT_EN.
module fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [7:0]                fetch_pc,
    input  logic [31:0]               fetch_inst1,
    input  logic [31:0]               fetch_inst2,
    input  logic                      redirect_valid,
    input  logic [7:0]                redirect_pc,
    input  logic [1:0]                deq_cnt,
    output logic                      out_valid0,
    output logic                      out_valid1,
    output logic [31:0]               out_inst0,
    output logic [31:0]               out_inst1,
    output logic [7:0]                out_pc0,
    output logic [7:0]                out_pc1,
    output logic [$clog2(DEPTH):0]    count
`ifdef FETCH_QUEUE_PERF_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 2;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          inflight;
    logic [7:0]    inflight_pc;

    logic [31:0]   mem_inst [DEPTH];
    logic [7:0]    mem_pc   [DEPTH];

    logic [1:0]    deq_req;
    logic [1:0]    deq_eff;
    logic          can_adv;
    logic [PW-1:0] head_nxt;
    logic [PW-1:0] head1;
    logic [CW-1:0] count_nxt;

    // Dequeue clamp, conservative credit check and next occupancy
    always_comb begin
        deq_req   = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        deq_eff   = deq_req;
        if (CW'(deq_req) > count) begin
            deq_eff = 2'(count);
        end
        can_adv   = (SW'(count) + SW'({inflight, 1'b0}) + SW'(2)) <= SW'(DEPTH);
        head_nxt  = head + PW'(deq_eff);
        head1     = head + PW'(1);
        count_nxt = count + (inflight ? CW'(2) : CW'(0)) - CW'(deq_eff);
    end

    // Control state: reset beats redirect, redirect discards the in-flight pair
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 8'h00;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc & 8'hFC;
            inflight    <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            head  <= head_nxt;
            count <= count_nxt;
            if (inflight) begin
                tail <= tail + PW'(2);
            end
            if (can_adv) begin
                fetch_pc    <= fetch_pc + 8'd8;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight    <= 1'b0;
            end
        end
    end

    // Queue storage: returned pair lands at tail and tail+1
    always_ff @(posedge clk) begin
        if (rst_n && !redirect_valid && inflight) begin
            mem_inst[tail]          <= fetch_inst1;
            mem_pc[tail]            <= inflight_pc;
            mem_inst[tail + PW'(1)] <= fetch_inst2;
            mem_pc[tail + PW'(1)]   <= inflight_pc + 8'd4;
        end
    end

`ifdef FETCH_QUEUE_PERF_CNT_EN
    // Cycles where the credit check blocked a request, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if (!redirect_valid && !can_adv && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

    // Head/head+1 views, zeroed when the slot holds nothing
    always_comb begin
        out_valid0 = (count >= CW'(1));
        out_valid1 = (count >= CW'(2));
        out_inst0  = 32'h0;
        out_pc0    = 8'h00;
        out_inst1  = 32'h0;
        out_pc1    = 8'h00;
        if (out_valid0) begin
            out_inst0 = mem_inst[head];
            out_pc0   = mem_pc[head];
        end
        if (out_valid1) begin
            out_inst1 = mem_inst[head1];
            out_pc1   = mem_pc[head1];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, wrap, reset, redirect, over-dequeue, streaming.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  fetch_pc, w_fetch_pc;
    logic [31:0] f1, f2, w_f1, w_f2;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [1:0]  deq_cnt, w_deq;
    logic        w_redir = 1'b0;
    logic [7:0]  w_redir_pc = 8'h00;
    logic        out_valid0, out_valid1, w_valid0, w_valid1;
    logic [31:0] out_inst0, out_inst1, w_inst0, w_inst1;
    logic [7:0]  out_pc0, out_pc1, w_pc0, w_pc1;
    logic [3:0]  count, w_count;
`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [15:0] stall_cnt, w_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] fill_pc  [6] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h20};
    logic [7:0] wrap_pc  [6] = '{8'hF8, 8'h00, 8'h08, 8'h10, 8'h18, 8'h18};
    logic [3:0] fill_cnt [6] = '{4'd0, 4'd0, 4'd2, 4'd4, 4'd6, 4'd8};
    logic       strm_v   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] strm_pc  [6] = '{8'h00, 8'h00, 8'h00, 8'h08, 8'h10, 8'h18};

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .fetch_inst1(f1), .fetch_inst2(f2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deq_cnt(deq_cnt),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_inst0(out_inst0), .out_inst1(out_inst1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .count(count)
`ifdef FETCH_QUEUE_PERF_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    fetch_queue #(.DEPTH(8), .RESET_PC(8'hF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fetch_pc(w_fetch_pc),
        .fetch_inst1(w_f1), .fetch_inst2(w_f2),
        .redirect_valid(w_redir), .redirect_pc(w_redir_pc), .deq_cnt(w_deq),
        .out_valid0(w_valid0), .out_valid1(w_valid1),
        .out_inst0(w_inst0), .out_inst1(w_inst1),
        .out_pc0(w_pc0), .out_pc1(w_pc1), .count(w_count)
`ifdef FETCH_QUEUE_PERF_CNT_EN
        , .stall_cnt(w_stall_cnt)
`endif
    );

    // Memory image: word k holds 0x1000_0000 + k
    function automatic logic [31:0] wordof(input logic [7:0] pc);
        return 32'h1000_0000 + {26'd0, pc[7:2]};
    endfunction

    // Fetch stage: samples the address at the edge, returns the pair next cycle
    always @(posedge clk) begin
        f1   <= wordof(fetch_pc);
        f2   <= wordof(fetch_pc + 8'd4);
        w_f1 <= wordof(w_fetch_pc);
        w_f2 <= wordof(w_fetch_pc + 8'd4);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; deq_cnt = 2'd0; w_deq = 2'd0;
        @(negedge clk);
        chk("rst_valid0", 32'(out_valid0), 32'd0);
        chk("rst_valid1", 32'(out_valid1), 32'd0);
        chk("rst_inst0", out_inst0, 32'h0);
        chk("rst_pc1", 32'(out_pc1), 32'h0);
        rst_n = 1'b1;

        // Fill with no dequeue, both instances
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fill_pc[%0d]", i), 32'(fetch_pc), 32'(fill_pc[i]));
            chk($sformatf("fill_cnt[%0d]", i), 32'(count), 32'(fill_cnt[i]));
            chk($sformatf("wrap_pc[%0d]", i), 32'(w_fetch_pc), 32'(wrap_pc[i]));
            chk($sformatf("wrap_cnt[%0d]", i), 32'(w_count), 32'(fill_cnt[i]));
            @(negedge clk);
        end
        chk("full_cnt", 32'(count), 32'd8);
        chk("full_fpc", 32'(fetch_pc), 32'h20);
        chk("full_v1", 32'(out_valid1), 32'd1);
        chk("full_inst0", out_inst0, 32'h1000_0000);
        chk("full_pc0", 32'(out_pc0), 32'h00);
        chk("full_inst1", out_inst1, 32'h1000_0001);
        chk("full_pc1", 32'(out_pc1), 32'h04);
        chk("wrap_pc0", 32'(w_pc0), 32'hF8);
        chk("wrap_inst0", w_inst0, 32'h1000_003E);
        chk("wrap_pc1", 32'(w_pc1), 32'hFC);
        chk("wrap_inst1", w_inst1, 32'h1000_003F);
        w_deq = 2'd2;
        @(negedge clk);
        chk("wrap2_pc0", 32'(w_pc0), 32'h00);
        chk("wrap2_inst0", w_inst0, 32'h1000_0000);
        chk("wrap2_pc1", 32'(w_pc1), 32'h04);
        chk("wrap2_cnt", 32'(w_count), 32'd6);
        chk("hold_cnt", 32'(count), 32'd8);
`ifdef FETCH_QUEUE_PERF_CNT_EN
        chk("stall3", 32'(stall_cnt), 32'd3);
`endif

        // Reset mid-operation with a concurrent redirect
        w_deq = 2'd0; rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h42;
        @(negedge clk);
        chk("mrst_fpc", 32'(fetch_pc), 32'h00);
        chk("mrst_cnt", 32'(count), 32'd0);
        chk("mrst_v0", 32'(out_valid0), 32'd0);
        chk("mrst_pc0", 32'(out_pc0), 32'h00);
`ifdef FETCH_QUEUE_PERF_CNT_EN
        chk("mrst_stall", 32'(stall_cnt), 32'd0);
`endif
        rst_n = 1'b1; redirect_valid = 1'b0;

        // Redirect while count=6 with a pair in flight
        repeat (4) @(negedge clk);
        chk("pre_redir_cnt", 32'(count), 32'd6);
        chk("pre_redir_fpc", 32'(fetch_pc), 32'h20);
        redirect_valid = 1'b1; redirect_pc = 8'h42;
        @(negedge clk);
        chk("redir_cnt", 32'(count), 32'd0);
        chk("redir_v0", 32'(out_valid0), 32'd0);
        chk("redir_fpc", 32'(fetch_pc), 32'h40);
        redirect_valid = 1'b0; deq_cnt = 2'd3;
        @(negedge clk);
        chk("ovr_cnt", 32'(count), 32'd0);
        chk("ovr_v0", 32'(out_valid0), 32'd0);
        chk("ovr_fpc", 32'(fetch_pc), 32'h48);
        @(negedge clk);
        chk("restart_pc0", 32'(out_pc0), 32'h40);
        chk("restart_inst0", out_inst0, 32'h1000_0010);
        chk("restart_pc1", 32'(out_pc1), 32'h44);
        chk("restart_cnt", 32'(count), 32'd2);
        @(negedge clk);
        chk("ovr2_pc0", 32'(out_pc0), 32'h48);
        chk("ovr2_cnt", 32'(count), 32'd2);
        deq_cnt = 2'd2;

        // Steady streaming, two per cycle
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("strm_pc0[%0d]", k), 32'(out_pc0), 32'(8'h48 + 8'(8 * k)));
            chk($sformatf("strm_pc1[%0d]", k), 32'(out_pc1), 32'(8'h4C + 8'(8 * k)));
            chk($sformatf("strm_v1[%0d]", k), 32'(out_valid1), 32'd1);
            chk($sformatf("strm_cnt[%0d]", k), 32'(count), 32'd2);
        end
        deq_cnt = 2'd1;
        @(negedge clk);
        chk("deq1_cnt", 32'(count), 32'd3);
        chk("deq1_pc0", 32'(out_pc0), 32'h74);
        chk("deq1_inst0", out_inst0, 32'h1000_001D);
        chk("deq1_pc1", 32'(out_pc1), 32'h78);
        deq_cnt = 2'd2;
        @(negedge clk);
        chk("deq2_cnt", 32'(count), 32'd3);
        chk("deq2_pc0", 32'(out_pc0), 32'h7C);
        chk("deq2_pc1", 32'(out_pc1), 32'h80);
`ifdef FETCH_QUEUE_PERF_CNT_EN
        chk("stall0", 32'(stall_cnt), 32'd0);
`endif

        // Streaming straight out of reset
        rst_n = 1'b0;
        @(negedge clk);
        chk("srst_cnt", 32'(count), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("sr_v0[%0d]", c), 32'(out_valid0), 32'(strm_v[c]));
            chk($sformatf("sr_v1[%0d]", c), 32'(out_valid1), 32'(strm_v[c]));
            chk($sformatf("sr_pc0[%0d]", c), 32'(out_pc0), 32'(strm_pc[c]));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
